exec_alu_stage: RTL and testbench

Execute stage directly downstream of the register file. Accepts ReadData1/ReadData2 operands plus opcode and destination register, and computes a 16-bit result. Returns the result to the register file write port (WriteData/regwrite/write address). Single-cycle logic ops; iterative 16-cycle multiply; valid/ready handshake on both sides so decode can stall.

---
 rtl/exec_pkg.sv | 58 +++++
 rtl/exec_muldiv_seq.sv | 95 +++++++++
 rtl/exec_alu_stage.sv | 165 ++++++++++++++++
 tb/tb_exec_alu_stage.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/exec_pkg.sv
// exec_pkg: shared opcodes, state encoding and opcode helpers for the execute stage.
// Honours the EXEC_DIV_EN macro: when defined, opcodes 11/12 are iterative DIV/REM.
package exec_pkg;

  localparam int DEF_DATA_W     = 16;
  localparam int DEF_ADDR_W     = 4;
  localparam int DEF_MUL_CYCLES = 16;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_SHL  = 4'd5;
  localparam logic [3:0] OP_SHR  = 4'd6;
  localparam logic [3:0] OP_SLT  = 4'd7;
  localparam logic [3:0] OP_PASS = 4'd8;
  localparam logic [3:0] OP_MUL  = 4'd9;
  localparam logic [3:0] OP_CMP  = 4'd10;
  localparam logic [3:0] OP_DIV  = 4'd11;
  localparam logic [3:0] OP_REM  = 4'd12;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Opcodes that run through the iterative sequencer instead of the 1-cycle ALU.
  function automatic logic is_seq(input logic [3:0] op);
    logic seq;
    seq = 1'b0;
    case (op)
      OP_MUL: seq = 1'b1;
`ifdef EXEC_DIV_EN
      OP_DIV, OP_REM: seq = 1'b1;
`endif
      default: seq = 1'b0;
    endcase
    return seq;
  endfunction

  // Opcodes whose result goes back into the register file; CMP and illegal ops never write.
  function automatic logic writes_reg(input logic [3:0] op);
    logic wr;
    wr = 1'b0;
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR,
      OP_SHL, OP_SHR, OP_SLT, OP_PASS, OP_MUL: wr = 1'b1;
`ifdef EXEC_DIV_EN
      OP_DIV, OP_REM: wr = 1'b1;
`endif
      default: wr = 1'b0;
    endcase
    return wr;
  endfunction

endpackage

// File: rtl/exec_muldiv_seq.sv
// exec_muldiv_seq: iterative shift-add multiplier, one partial product per clock.
// With EXEC_DIV_EN defined it also performs unsigned restoring division (quotient or remainder).
// A start pulse loads the operands; o_done is high during the last iteration and o_result
// carries the final value in that same cycle so the caller can latch it on that edge.
module exec_muldiv_seq #(
  parameter int DATA_W = 16,
  parameter int CYCLES = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              i_start,
`ifdef EXEC_DIV_EN
  input  logic              i_isDiv,
  input  logic              i_wantRem,
`endif
  input  logic [DATA_W-1:0] i_opA,
  input  logic [DATA_W-1:0] i_opB,
  output logic              o_done,
  output logic [DATA_W-1:0] o_result
);

  localparam int CNT_W = $clog2(CYCLES);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CYCLES - 1);

  logic              r_busy;
  logic [CNT_W-1:0]  r_count;
  logic [DATA_W-1:0] r_a;
  logic [DATA_W-1:0] r_b;
  logic [DATA_W-1:0] r_acc;

  logic [DATA_W-1:0] w_pp;
  logic [DATA_W-1:0] w_accNext;

  assign w_pp      = r_b[r_count] ? (r_a << r_count) : '0;
  assign w_accNext = r_acc + w_pp;
  assign o_done    = r_busy & (r_count == LAST);

`ifdef EXEC_DIV_EN
  logic              r_isDiv;
  logic              r_wantRem;
  logic [DATA_W-1:0] r_quo;
  logic [DATA_W-1:0] r_rem;

  logic [DATA_W:0]   w_shifted;
  logic              w_ge;
  logic [DATA_W-1:0] w_remNext;
  logic [DATA_W-1:0] w_quoNext;

  assign w_shifted = {r_rem, r_quo[DATA_W-1]};
  assign w_ge      = (w_shifted >= {1'b0, r_b});
  assign w_remNext = w_ge ? DATA_W'(w_shifted - {1'b0, r_b}) : DATA_W'(w_shifted);
  assign w_quoNext = {r_quo[DATA_W-2:0], w_ge};

  // Pick the finished value: product, quotient or remainder.
  always_comb begin
    o_result = w_accNext;
    if (r_isDiv) begin
      o_result = r_wantRem ? w_remNext : w_quoNext;
    end
  end
`else
  assign o_result = w_accNext;
`endif

  // Load operands on start, then advance one iteration per clock until the last one.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_busy  <= 1'b0;
      r_count <= '0;
    end else if (i_start) begin
      r_busy  <= 1'b1;
      r_count <= '0;
      r_a     <= i_opA;
      r_b     <= i_opB;
      r_acc   <= '0;
`ifdef EXEC_DIV_EN
      r_isDiv   <= i_isDiv;
      r_wantRem <= i_wantRem;
      r_quo     <= i_opA;
      r_rem     <= '0;
`endif
    end else if (r_busy) begin
      r_count <= r_count + 1'b1;
      r_acc   <= w_accNext;
`ifdef EXEC_DIV_EN
      r_quo   <= w_quoNext;
      r_rem   <= w_remNext;
`endif
      if (o_done) begin
        r_busy <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/exec_alu_stage.sv
// exec_alu_stage: execute stage between register file read ports and its write port.
// Single-cycle logic/arith ops, 16-cycle iterative multiply, valid/ready on both sides.
// Macro EXEC_DIV_EN enables iterative unsigned DIV (11) and REM (12); otherwise they are illegal.
module exec_alu_stage
  import exec_pkg::*;
#(
  parameter int DATA_W     = DEF_DATA_W,
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int MUL_CYCLES = DEF_MUL_CYCLES
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        op,
  input  logic [DATA_W-1:0] operand_a,
  input  logic [DATA_W-1:0] operand_b,
  input  logic [ADDR_W-1:0] dest_reg,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] result,
  output logic [ADDR_W-1:0] wr_reg,
  output logic              regwrite,
  output logic              flag_z,
  output logic              flag_c,
  output logic              illegal_op
);

  localparam int SHIFT_W = $clog2(DATA_W);

  state_t            r_state;
  logic              r_outValid;
  logic [DATA_W-1:0] r_result;
  logic [ADDR_W-1:0] r_wrReg;
  logic [3:0]        r_op;
  logic              r_flagZ;
  logic              r_flagC;
  logic              r_illegal;

  logic              w_inReady;
  logic              w_accept;
  logic              w_isSeq;
  logic              w_seqStart;
  logic              w_seqDone;
  logic [DATA_W-1:0] w_seqResult;
  logic [DATA_W:0]   w_sum;
  logic [DATA_W:0]   w_diff;
  logic [DATA_W-1:0] w_aluResult;
  logic              w_aluCarry;
  logic              w_aluIllegal;

  assign w_inReady  = (r_state == ST_IDLE) | ((r_state == ST_DONE) & out_ready);
  assign w_accept   = in_valid & w_inReady;
  assign w_isSeq    = is_seq(op);
  assign w_seqStart = w_accept & w_isSeq;
  assign w_sum      = {1'b0, operand_a} + {1'b0, operand_b};
  assign w_diff     = {1'b0, operand_a} - {1'b0, operand_b};

  assign in_ready   = w_inReady;
  assign out_valid  = r_outValid;
  assign result     = r_result;
  assign wr_reg     = r_wrReg;
  assign flag_z     = r_flagZ;
  assign flag_c     = r_flagC;
  assign illegal_op = r_illegal;
  assign regwrite   = r_outValid & out_ready & writes_reg(r_op);

  // Single-cycle datapath; the carry bit is the extra top bit of the widened add/subtract.
  always_comb begin
    w_aluResult  = '0;
    w_aluCarry   = 1'b0;
    w_aluIllegal = 1'b0;
    case (op)
      OP_ADD: begin
        w_aluResult = w_sum[DATA_W-1:0];
        w_aluCarry  = w_sum[DATA_W];
      end
      OP_SUB, OP_CMP: begin
        w_aluResult = w_diff[DATA_W-1:0];
        w_aluCarry  = w_diff[DATA_W];
      end
      OP_AND:  w_aluResult = operand_a & operand_b;
      OP_OR:   w_aluResult = operand_a | operand_b;
      OP_XOR:  w_aluResult = operand_a ^ operand_b;
      OP_SHL:  w_aluResult = operand_a << operand_b[SHIFT_W-1:0];
      OP_SHR:  w_aluResult = operand_a >> operand_b[SHIFT_W-1:0];
      OP_SLT:  w_aluResult[0] = (operand_a < operand_b);
      OP_PASS: w_aluResult = operand_b;
      OP_MUL:  w_aluResult = '0;
`ifdef EXEC_DIV_EN
      OP_DIV, OP_REM: w_aluResult = '0;
`endif
      default: w_aluIllegal = 1'b1;
    endcase
  end

  exec_muldiv_seq #(
    .DATA_W (DATA_W),
    .CYCLES (MUL_CYCLES)
  ) u_muldiv (
    .clock     (clock),
    .reset     (reset),
    .i_start   (w_seqStart),
`ifdef EXEC_DIV_EN
    .i_isDiv   ((op == OP_DIV) || (op == OP_REM)),
    .i_wantRem (op == OP_REM),
`endif
    .i_opA     (operand_a),
    .i_opB     (operand_b),
    .o_done    (w_seqDone),
    .o_result  (w_seqResult)
  );

  // Stage control: accept, iterate, hold the result until writeback takes it.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_outValid <= 1'b0;
      r_result   <= '0;
      r_wrReg    <= '0;
      r_op       <= '0;
      r_flagZ    <= 1'b0;
      r_flagC    <= 1'b0;
      r_illegal  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (w_accept) begin
            r_wrReg <= dest_reg;
            r_op    <= op;
            if (w_isSeq) begin
              r_state    <= ST_BUSY;
              r_outValid <= 1'b0;
            end else begin
              r_state    <= ST_DONE;
              r_outValid <= 1'b1;
              r_result   <= w_aluResult;
              r_flagZ    <= (w_aluResult == '0);
              r_flagC    <= w_aluCarry;
              r_illegal  <= w_aluIllegal;
            end
          end else if ((r_state == ST_DONE) && out_ready) begin
            r_state    <= ST_IDLE;
            r_outValid <= 1'b0;
          end
        end
        ST_BUSY: begin
          if (w_seqDone) begin
            r_state    <= ST_DONE;
            r_outValid <= 1'b1;
            r_result   <= w_seqResult;
            r_flagZ    <= (w_seqResult == '0);
            r_flagC    <= 1'b0;
            r_illegal  <= 1'b0;
          end
        end
        default: begin
          r_state    <= ST_IDLE;
          r_outValid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_exec_alu_stage.sv
// tb_exec_alu_stage: directed checks plus randomized traffic against a behavioural model.
`timescale 1ns/1ps
module tb_exec_alu_stage;

  logic        clock = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  op;
  logic [15:0] operand_a;
  logic [15:0] operand_b;
  logic [3:0]  dest_reg;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] result;
  logic [3:0]  wr_reg;
  logic        regwrite;
  logic        flag_z;
  logic        flag_c;
  logic        illegal_op;

  int checks   = 0;
  int failures = 0;

  // Model state: one outstanding operation and how many edges until it is visible.
  bit          mArmed   = 1'b0;
  bit          mPending = 1'b0;
  int          mLeft    = 0;
  logic [15:0] mRes;
  logic        mC;
  logic        mIll;
  logic        mWr;
  logic [3:0]  mDest;

  always #5 clock = ~clock;

  exec_alu_stage dut (
    .clock      (clock),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .op         (op),
    .operand_a  (operand_a),
    .operand_b  (operand_b),
    .dest_reg   (dest_reg),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .result     (result),
    .wr_reg     (wr_reg),
    .regwrite   (regwrite),
    .flag_z     (flag_z),
    .flag_c     (flag_c),
    .illegal_op (illegal_op)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got=%0h want=%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Reference semantics of every opcode, written as plain integer arithmetic.
  function automatic void refOp(input logic [3:0] o, input logic [15:0] a, input logic [15:0] b,
                                output logic [15:0] r, output logic c, output logic ill, output logic wr);
    int unsigned ua;
    int unsigned ub;
    ua  = a;
    ub  = b;
    r   = 16'h0;
    c   = 1'b0;
    ill = 1'b0;
    wr  = 1'b1;
    case (o)
      4'd0: begin r = 16'(ua + ub); c = ((ua + ub) > 32'd65535); end
      4'd1: begin r = 16'(ua - ub); c = (ua < ub); end
      4'd2: r = a & b;
      4'd3: r = a | b;
      4'd4: r = a ^ b;
      4'd5: r = 16'(ua << (ub % 16));
      4'd6: r = 16'(ua >> (ub % 16));
      4'd7: r = (ua < ub) ? 16'd1 : 16'd0;
      4'd8: r = b;
      4'd9: r = 16'(ua * ub);
      4'd10: begin r = 16'(ua - ub); c = (ua < ub); wr = 1'b0; end
`ifdef EXEC_DIV_EN
      4'd11: r = (ub == 0) ? 16'hFFFF : 16'(ua / ub);
      4'd12: r = (ub == 0) ? a : 16'(ua % ub);
`endif
      default: begin ill = 1'b1; wr = 1'b0; r = 16'h0; end
    endcase
  endfunction

  function automatic bit isMultiCycle(input logic [3:0] o);
`ifdef EXEC_DIV_EN
    return (o == 4'd9) || (o == 4'd11) || (o == 4'd12);
`else
    return (o == 4'd9);
`endif
  endfunction

  function automatic logic [15:0] pickVal();
    logic [15:0] v;
    case ($urandom_range(0, 7))
      0: v = 16'h0000;
      1: v = 16'hFFFF;
      2: v = 16'(($urandom_range(0, 15)));
      default: v = 16'($urandom);
    endcase
    return v;
  endfunction

  // Every cycle: compare DUT against the model, then advance the model across the next edge.
  always @(negedge clock) begin
    bit expValid;
    bit expReady;
    expValid = mPending && (mLeft == 0);
    expReady = !mPending || (expValid && out_ready);
    if (mArmed) begin
      checkOutput("out_valid", 32'(out_valid), 32'(expValid));
      checkOutput("in_ready", 32'(in_ready), 32'(expReady));
      if (expValid) begin
        checkOutput("result", 32'(result), 32'(mRes));
        checkOutput("wr_reg", 32'(wr_reg), 32'(mDest));
        checkOutput("flag_z", 32'(flag_z), 32'(mRes == 16'h0));
        checkOutput("flag_c", 32'(flag_c), 32'(mC));
        checkOutput("illegal_op", 32'(illegal_op), 32'(mIll));
        checkOutput("regwrite", 32'(regwrite), 32'(out_ready & mWr));
      end else begin
        checkOutput("regwrite_idle", 32'(regwrite), 32'd0);
      end
    end
    if (reset) begin
      mArmed   = 1'b1;
      mPending = 1'b0;
      mLeft    = 0;
    end else if (mPending && (mLeft > 0)) begin
      mLeft = mLeft - 1;
    end else begin
      if (expValid && out_ready) mPending = 1'b0;
      if (in_valid && expReady) begin
        refOp(op, operand_a, operand_b, mRes, mC, mIll, mWr);
        mDest    = dest_reg;
        mPending = 1'b1;
        mLeft    = isMultiCycle(op) ? 16 : 0;
      end
    end
  end

  // Present one bundle and hold it until the stage takes it; returns #1 after the accepting edge.
  task automatic applyStimulus(input logic [3:0] o, input logic [15:0] a, input logic [15:0] b, input logic [3:0] d);
    bit taken;
    taken     = 1'b0;
    op        = o;
    operand_a = a;
    operand_b = b;
    dest_reg  = d;
    in_valid  = 1'b1;
    for (int i = 0; i < 40 && !taken; i++) begin
      @(negedge clock);
      taken = in_ready && !reset;
      @(posedge clock);
      #1;
    end
    in_valid = 1'b0;
    if (!taken) begin
      checks++;
      failures++;
      $display("[TB] FAIL accept_timeout: got=no_accept want=accept op=%0d", o);
    end
  endtask

  task automatic waitValid();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      if (out_valid) seen = 1'b1;
      else begin
        @(posedge clock);
        #1;
      end
    end
    if (!seen) begin
      checks++;
      failures++;
      $display("[TB] FAIL valid_timeout: got=out_valid0 want=out_valid1");
    end
  endtask

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    op        = 4'd0;
    operand_a = 16'h0;
    operand_b = 16'h0;
    dest_reg  = 4'd0;
    out_ready = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
    checkOutput("rst_result", 32'(result), 32'd0);
    checkOutput("rst_wr_reg", 32'(wr_reg), 32'd0);
    checkOutput("rst_flags", 32'({flag_z, flag_c, illegal_op}), 32'd0);

    // Reset held two cycles in the middle of a multiply discards it.
    applyStimulus(4'd9, 16'd3, 16'd5, 4'd1);
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    checkOutput("midmul_out_valid", 32'(out_valid), 32'd0);
    checkOutput("midmul_in_ready", 32'(in_ready), 32'd1);
    repeat (20) @(posedge clock);
    #1;
    checkOutput("midmul_discarded", 32'(out_valid), 32'd0);

    // Reset coinciding with a valid bundle: nothing is accepted.
    in_valid  = 1'b1;
    op        = 4'd0;
    operand_a = 16'd1;
    operand_b = 16'd1;
    reset     = 1'b1;
    @(posedge clock);
    #1;
    reset    = 1'b0;
    in_valid = 1'b0;
    checkOutput("rst_accept_out_valid", 32'(out_valid), 32'd0);

    // ADD with carry out and zero result.
    applyStimulus(4'd0, 16'hFFFF, 16'h0001, 4'd3);
    checkOutput("add_result", 32'(result), 32'h0);
    checkOutput("add_flag_z", 32'(flag_z), 32'd1);
    checkOutput("add_flag_c", 32'(flag_c), 32'd1);
    checkOutput("add_regwrite", 32'(regwrite), 32'd1);
    checkOutput("add_wr_reg", 32'(wr_reg), 32'd3);

    // Back-to-back SUB then XOR.
    applyStimulus(4'd1, 16'h0010, 16'h0001, 4'd5);
    checkOutput("sub_result", 32'(result), 32'h000F);
    checkOutput("sub_flag_c", 32'(flag_c), 32'd0);
    checkOutput("sub_in_ready", 32'(in_ready), 32'd1);
    applyStimulus(4'd4, 16'h0F00, 16'h00F0, 4'd6);
    checkOutput("xor_result", 32'(result), 32'h0FF0);
    checkOutput("xor_in_ready", 32'(in_ready), 32'd1);

    // MUL latency, stall while busy, result held under back-pressure.
    out_ready = 1'b0;
    @(posedge clock);
    #1;
    out_ready = 1'b1;
    @(posedge clock);
    #1;
    out_ready = 1'b0;
    applyStimulus(4'd9, 16'h0101, 16'h0022, 4'd7);
    for (int k = 0; k < 16; k++) begin
      checkOutput("mul_busy_in_ready", 32'(in_ready), 32'd0);
      checkOutput("mul_busy_out_valid", 32'(out_valid), 32'd0);
      @(posedge clock);
      #1;
    end
    checkOutput("mul_out_valid", 32'(out_valid), 32'd1);
    checkOutput("mul_result", 32'(result), 32'h2222);
    repeat (3) begin
      @(posedge clock);
      #1;
      checkOutput("mul_hold_result", 32'(result), 32'h2222);
      checkOutput("mul_hold_regwrite", 32'(regwrite), 32'd0);
    end
    out_ready = 1'b1;
    #1;
    checkOutput("mul_regwrite", 32'(regwrite), 32'd1);
    @(posedge clock);
    #1;
    checkOutput("mul_drained", 32'(out_valid), 32'd0);

    // CMP sets flags without writing; opcode 15 is illegal.
    applyStimulus(4'd10, 16'd5, 16'd5, 4'd2);
    checkOutput("cmp_flag_z", 32'(flag_z), 32'd1);
    checkOutput("cmp_regwrite", 32'(regwrite), 32'd0);
    applyStimulus(4'd15, 16'h1234, 16'h5678, 4'd4);
    checkOutput("ill_flag", 32'(illegal_op), 32'd1);
    checkOutput("ill_result", 32'(result), 32'd0);
    checkOutput("ill_regwrite", 32'(regwrite), 32'd0);

`ifdef EXEC_DIV_EN
    applyStimulus(4'd11, 16'h2222, 16'h0002, 4'd8);
    waitValid();
    checkOutput("div_result", 32'(result), 32'h1111);
    applyStimulus(4'd11, 16'h1234, 16'h0000, 4'd8);
    waitValid();
    checkOutput("div0_result", 32'(result), 32'hFFFF);
    checkOutput("div0_illegal", 32'(illegal_op), 32'd0);
    applyStimulus(4'd12, 16'd7, 16'd3, 4'd9);
    waitValid();
    checkOutput("rem_result", 32'(result), 32'd1);
`else
    applyStimulus(4'd11, 16'h2222, 16'h0002, 4'd8);
    checkOutput("div_off_valid", 32'(out_valid), 32'd1);
    checkOutput("div_off_illegal", 32'(illegal_op), 32'd1);
    checkOutput("div_off_result", 32'(result), 32'd0);
`endif

    // Randomized traffic with back-pressure and occasional resets.
    for (int i = 0; i < 1500; i++) begin
      in_valid  = ($urandom_range(0, 9) < 7);
      op        = 4'($urandom_range(0, 15));
      operand_a = pickVal();
      operand_b = pickVal();
      dest_reg  = 4'($urandom_range(0, 15));
      out_ready = ($urandom_range(0, 3) != 0);
      reset     = ($urandom_range(0, 99) == 0);
      @(posedge clock);
      #1;
    end
    reset     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (40) @(posedge clock);
    #1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
